// File: rtl/mst_apb_bridge.sv
// APB3 slave to native request/ack master bridge.
// One APB access is converted into a native request, the bridge waits for the
// downstream ack (or a timeout) and then answers the APB master with a single
// pready cycle. All outputs come straight from flops.
//
// Native handshake: a request is transferred in a cycle where req_vld=1 and
// fsm__mst__req_rdy=1; an ack is accepted either in that same cycle
// (fsm__mst__ack_vld=1 together with req_rdy) or later in a cycle where
// ack_rdy=1 and fsm__mst__ack_vld=1. An ack presented at any other time is ignored.
module mst_apb_bridge #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // APB3 slave side
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    // native master side
    output logic                  mst__fsm__req_vld,
    output logic                  mst__fsm__rd_en,
    output logic                  mst__fsm__wr_en,
    output logic [ADDR_WIDTH-1:0] mst__fsm__addr,
    output logic [DATA_WIDTH-1:0] mst__fsm__wr_data,
    output logic                  mst__fsm__sync_reset,
    output logic                  mst__fsm__ack_rdy,
    input  logic                  fsm__mst__req_rdy,
    input  logic                  fsm__mst__ack_vld,
    input  logic [DATA_WIDTH-1:0] fsm__mst__rd_data
);

    // Counter wide enough to hold TIMEOUT; a TIMEOUT of 0 turns the abort off.
    localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pwrite_q, pwrite_d;

    logic                    req_vld_q, req_vld_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    ack_rdy_q, ack_rdy_d;
    logic                    sync_reset_q, sync_reset_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic                    timeout_hit;
    logic [CNT_W-1:0]        cnt_inc;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state and next-output logic for the bridge FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pwrite_d     = pwrite_q;
        req_vld_d    = req_vld_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        ack_rdy_d    = ack_rdy_q;
        sync_reset_d = 1'b0;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        prdata_d     = '0;

        case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    state_d   = REQ;
                    cnt_d     = '0;
                    pwrite_d  = pwrite;
                    req_vld_d = 1'b1;
                    wr_en_d   = pwrite;
                    rd_en_d   = !pwrite;
                    addr_d    = paddr;
                    wr_data_d = pwdata;
                end
            end

            REQ: begin
                cnt_d = cnt_inc;
                if (fsm__mst__req_rdy && fsm__mst__ack_vld) begin
                    // Request and ack in one cycle: skip WAIT_ACK.
                    state_d   = RESP;
                    req_vld_d = 1'b0;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    addr_d    = '0;
                    wr_data_d = '0;
                    pready_d  = 1'b1;
                    prdata_d  = pwrite_q ? '0 : fsm__mst__rd_data;
                end else if (timeout_hit) begin
                    state_d      = RESP;
                    req_vld_d    = 1'b0;
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    addr_d       = '0;
                    wr_data_d    = '0;
                    sync_reset_d = 1'b1;
                    pready_d     = 1'b1;
                    pslverr_d    = 1'b1;
                end else if (fsm__mst__req_rdy) begin
                    state_d   = WAIT_ACK;
                    req_vld_d = 1'b0;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    addr_d    = '0;
                    wr_data_d = '0;
                    ack_rdy_d = 1'b1;
                end
            end

            WAIT_ACK: begin
                cnt_d = cnt_inc;
                // An ack in the timeout cycle still completes normally.
                if (fsm__mst__ack_vld) begin
                    state_d   = RESP;
                    ack_rdy_d = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = pwrite_q ? '0 : fsm__mst__rd_data;
                end else if (timeout_hit) begin
                    state_d      = RESP;
                    ack_rdy_d    = 1'b0;
                    sync_reset_d = 1'b1;
                    pready_d     = 1'b1;
                    pslverr_d    = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pwrite_q     <= 1'b0;
            req_vld_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            ack_rdy_q    <= 1'b0;
            sync_reset_q <= 1'b0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            prdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwrite_q     <= pwrite_d;
            req_vld_q    <= req_vld_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            ack_rdy_q    <= ack_rdy_d;
            sync_reset_q <= sync_reset_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            prdata_q     <= prdata_d;
        end
    end

    assign mst__fsm__req_vld    = req_vld_q;
    assign mst__fsm__rd_en      = rd_en_q;
    assign mst__fsm__wr_en      = wr_en_q;
    assign mst__fsm__addr       = addr_q;
    assign mst__fsm__wr_data    = wr_data_q;
    assign mst__fsm__ack_rdy    = ack_rdy_q;
    assign mst__fsm__sync_reset = sync_reset_q;
    assign pready               = pready_q;
    assign pslverr              = pslverr_q;
    assign prdata               = prdata_q;

endmodule
